// File: rtl/mu0_ctrl_seq.sv
// ---------------------------------------------------------------------------
// mu0_ctrl_seq
// Control sequencer for the multi-cycle MU0 CPU. Steps through the
// FETCH_ADDR / FETCH_DATA / EXEC_ADDR / EXEC_DATA phases, decodes the opcode
// into datapath strobes and manages the memory req/ack handshake, including
// a data-phase timeout fault, single-step parking, a saturating
// retired-instruction counter and illegal-opcode trapping.
//
// State table:
//   state      | code | meaning
//   FETCH_ADDR | 0    | present PC to memory, start instruction fetch
//   FETCH_DATA | 1    | wait for instruction word, load IR and bump PC on ack
//   EXEC_ADDR  | 2    | decode; memory ops present operand, others retire
//   EXEC_DATA  | 3    | operand transfer, ACC update on ack, then retire
//   HALTED     | 4    | STP executed, terminal until reset
//   STEP_WAIT  | 5    | single-step park after retire, released by step
//   FAULT      | 6    | illegal opcode or memory timeout, terminal until reset
//
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_opcode            instruction register opcode field
//   i_acc_zero/neg      accumulator flags for conditional jumps
//   i_mem_ack           memory completion for the current request
//   i_step_mode/i_step  single-step control
//   o_running/o_fault   run status
//   o_state             current state code (see table)
//   o_mem_req/we        memory request / write
//   o_addr_sel          address mux: 0 = PC, 1 = operand
//   o_ir_load, o_pc_inc, o_pc_load, o_acc_load, o_acc_op, o_out_valid
//                       single-cycle datapath strobes
//   o_instr_count       retired instructions, saturating
// ---------------------------------------------------------------------------
module mu0_ctrl_seq #(
    parameter int OPCODE_W = 4,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_acc_zero,
    input  logic                i_acc_neg,
    input  logic                i_mem_ack,
    input  logic                i_step_mode,
    input  logic                i_step,
    output logic                o_running,
    output logic                o_fault,
    output logic [2:0]          o_state,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic                o_addr_sel,
    output logic                o_ir_load,
    output logic                o_pc_inc,
    output logic                o_pc_load,
    output logic                o_acc_load,
    output logic [1:0]          o_acc_op,
    output logic                o_out_valid,
    output logic [CNT_W-1:0]    o_instr_count
);

    localparam logic [2:0] S_FETCH_ADDR = 3'd0;
    localparam logic [2:0] S_FETCH_DATA = 3'd1;
    localparam logic [2:0] S_EXEC_ADDR  = 3'd2;
    localparam logic [2:0] S_EXEC_DATA  = 3'd3;
    localparam logic [2:0] S_HALTED     = 3'd4;
    localparam logic [2:0] S_STEP_WAIT  = 3'd5;
    localparam logic [2:0] S_FAULT      = 3'd6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;

    // The wait counter only ever needs to reach TIMEOUT-1: the no-ack cycle
    // seen with that value is the last one allowed.
    localparam int              WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;

    logic [2:0]       r_state;
    logic [3:0]       r_opcode;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_count;

    logic [2:0] w_next;
    logic [2:0] w_retire_next;
    logic [3:0] w_op4;
    logic       w_op_hi_nz;
    logic       w_op_mem;
    logic       w_op_legal;
    logic       w_data_phase;
    logic       w_timeout;
    logic       w_retire;
    logic       w_ir_load;
    logic       w_pc_inc;
    logic       w_pc_load;
    logic       w_acc_load;
    logic [1:0] w_acc_op;
    logic       w_out_valid;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_addr_sel;

    assign w_op4      = 4'(i_opcode);
    assign w_op_hi_nz = |(i_opcode >> 4);
    assign w_op_mem   = !w_op_hi_nz && (w_op4 <= OP_SUB);
    assign w_op_legal = !w_op_hi_nz && (w_op4 <= OP_OUT);

    assign w_data_phase  = (r_state == S_FETCH_DATA) || (r_state == S_EXEC_DATA);
    assign w_timeout     = (TIMEOUT != 0) && w_data_phase && !i_mem_ack
                           && (r_wait_cnt == WC_LAST);
    assign w_retire_next = i_step_mode ? S_STEP_WAIT : S_FETCH_ADDR;

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_acc_load  = 1'b0;
        w_acc_op    = 2'b00;
        w_out_valid = 1'b0;
        case (r_state)
            S_FETCH_ADDR: w_next = S_FETCH_DATA;
            S_FETCH_DATA: begin
                if (i_mem_ack) begin
                    w_ir_load = 1'b1;
                    w_pc_inc  = 1'b1;
                    w_next    = S_EXEC_ADDR;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_EXEC_ADDR: begin
                if (!w_op_legal) begin
                    w_next = S_FAULT;
                end else if (w_op_mem) begin
                    w_next = S_EXEC_DATA;
                end else begin
                    w_retire = 1'b1;
                    w_next   = (w_op4 == OP_STP) ? S_HALTED : w_retire_next;
                    case (w_op4)
                        OP_JMP:  w_pc_load   = 1'b1;
                        OP_JGE:  w_pc_load   = !i_acc_neg;
                        OP_JNE:  w_pc_load   = !i_acc_zero;
                        OP_OUT:  w_out_valid = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_EXEC_DATA: begin
                if (i_mem_ack) begin
                    w_retire = 1'b1;
                    w_next   = w_retire_next;
                    case (r_opcode)
                        OP_LDA: begin w_acc_load = 1'b1; w_acc_op = 2'b00; end
                        OP_ADD: begin w_acc_load = 1'b1; w_acc_op = 2'b01; end
                        OP_SUB: begin w_acc_load = 1'b1; w_acc_op = 2'b10; end
                        default: ;
                    endcase
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_STEP_WAIT: begin
                if (i_step || !i_step_mode) begin
                    w_next = S_FETCH_ADDR;
                end
            end
            default: ;
        endcase
    end

    // Memory-side outputs. EXEC_ADDR presents the operand address for memory
    // ops straight from the live opcode, since the latch only lands at the
    // end of that cycle.
    always_comb begin
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_addr_sel = 1'b0;
        case (r_state)
            S_FETCH_ADDR, S_FETCH_DATA: w_mem_req = 1'b1;
            S_EXEC_ADDR: begin
                w_mem_req  = w_op_mem;
                w_addr_sel = w_op_mem;
                w_mem_we   = w_op_mem && (w_op4 == OP_STO);
            end
            S_EXEC_DATA: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (r_opcode == OP_STO);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_FETCH_ADDR;
            r_opcode   <= 4'h0;
            r_wait_cnt <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC_ADDR) begin
                r_opcode <= w_op4;
            end
            if ((w_next == S_FETCH_DATA && r_state != S_FETCH_DATA) ||
                (w_next == S_EXEC_DATA  && r_state != S_EXEC_DATA)) begin
                r_wait_cnt <= '0;
            end else if (w_data_phase && !i_mem_ack) begin
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            end
            if (w_retire && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Request lines are gated by reset so an in-flight access is dropped
    // the moment reset asserts, not at the next edge.
    assign o_mem_req     = w_mem_req & ~i_rst;
    assign o_mem_we      = w_mem_we & ~i_rst;
    assign o_addr_sel    = w_addr_sel;
    assign o_running     = (r_state != S_HALTED) && (r_state != S_FAULT);
    assign o_fault       = (r_state == S_FAULT);
    assign o_state       = r_state;
    assign o_ir_load     = w_ir_load;
    assign o_pc_inc      = w_pc_inc;
    assign o_pc_load     = w_pc_load;
    assign o_acc_load    = w_acc_load;
    assign o_acc_op      = w_acc_op;
    assign o_out_valid   = w_out_valid;
    assign o_instr_count = r_count;

endmodule

// File: tb/tb_mu0_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_mu0_ctrl_seq
// Directed bench for mu0_ctrl_seq. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge. instr_count is 3 bits wide
// here so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_mu0_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       acc_zero = 1'b0;
    logic       acc_neg = 1'b0;
    logic       mem_ack = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;

    logic       running, fault, mem_req, mem_we, addr_sel;
    logic       ir_load, pc_inc, pc_load, acc_load, out_valid;
    logic [1:0] acc_op;
    logic [2:0] state;
    logic [2:0] count;

    logic [4:0] moore;
    logic [6:0] pulses;

    int checks = 0;
    int errors = 0;

    assign moore  = {running, fault, mem_req, mem_we, addr_sel};
    assign pulses = {ir_load, pc_inc, pc_load, acc_load, acc_op, out_valid};

    mu0_ctrl_seq #(.OPCODE_W(4), .TIMEOUT(15), .CNT_W(3)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_opcode      (opcode),
        .i_acc_zero    (acc_zero),
        .i_acc_neg     (acc_neg),
        .i_mem_ack     (mem_ack),
        .i_step_mode   (step_mode),
        .i_step        (step),
        .o_running     (running),
        .o_fault       (fault),
        .o_state       (state),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_addr_sel    (addr_sel),
        .o_ir_load     (ir_load),
        .o_pc_inc      (pc_inc),
        .o_pc_load     (pc_load),
        .o_acc_load    (acc_load),
        .o_acc_op      (acc_op),
        .o_out_valid   (out_valid),
        .o_instr_count (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the bench at the start of the first FETCH_ADDR cycle.
    task automatic do_reset();
        rst = 1'b1;
        opcode = 4'h0; acc_zero = 1'b0; acc_neg = 1'b0;
        mem_ack = 1'b0; step_mode = 1'b0; step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++;
        if (moore !== 5'b10000) begin errors++; $display("FAIL reset_moore got %b exp 10000", moore); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++;
        if (pulses !== 7'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000000", pulses); end
        next_cycle();
        rst = 1'b0;
        sample();
        checks++;
        if (moore !== 5'b10100) begin errors++; $display("FAIL release_moore got %b exp 10100", moore); end
    endtask

    task automatic test_mem_ops();
        logic [3:0] ops [3];
        logic [6:0] exp_p;
        ops[0] = 4'h0; ops[1] = 4'h2; ops[2] = 4'h3;
        do_reset();
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            for (int c = 0; c < 4; c++) begin
                sample();
                exp_p = 7'b0;
                if (c == 1) exp_p = 7'b1100000;
                if (c == 3) exp_p = {4'b0001, 2'(k), 1'b0};
                checks++;
                if (state !== 3'(c)) begin errors++; $display("FAIL memop_state op%0d c%0d got %0d exp %0d", k, c, state, c); end
                checks++;
                if (pulses !== exp_p) begin errors++; $display("FAIL memop_pulses op%0d c%0d got %b exp %b", k, c, pulses, exp_p); end
                if (c != 2) begin
                    checks++;
                    if (moore !== ((c == 3) ? 5'b10101 : 5'b10100)) begin
                        errors++; $display("FAIL memop_moore op%0d c%0d got %b", k, c, moore);
                    end
                end
                next_cycle();
            end
            checks++;
            if (state !== 3'd0 || count !== 3'(k + 1)) begin
                errors++; $display("FAIL memop_retire op%0d got state %0d count %0d exp 0 %0d", k, state, count, k + 1);
            end
        end
    endtask

    task automatic test_jumps();
        logic [3:0] ops [5];
        logic       zs [5];
        logic       ns [5];
        logic       ex [5];
        ops[0] = 4'h6; zs[0] = 0; ns[0] = 0; ex[0] = 1;
        ops[1] = 4'h6; zs[1] = 1; ns[1] = 0; ex[1] = 0;
        ops[2] = 4'h5; zs[2] = 0; ns[2] = 1; ex[2] = 0;
        ops[3] = 4'h5; zs[3] = 0; ns[3] = 0; ex[3] = 1;
        ops[4] = 4'h4; zs[4] = 1; ns[4] = 1; ex[4] = 1;
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i]; acc_zero = zs[i]; acc_neg = ns[i];
            for (int c = 0; c < 3; c++) begin
                sample();
                checks++;
                if (state !== 3'(c)) begin errors++; $display("FAIL jump_state case%0d c%0d got %0d exp %0d", i, c, state, c); end
                if (c == 2) begin
                    checks++;
                    if (pulses !== {2'b00, ex[i], 4'b0000}) begin
                        errors++; $display("FAIL jump_pc_load case%0d got %b exp %b", i, pulses, {2'b00, ex[i], 4'b0000});
                    end
                end
                next_cycle();
            end
            checks++;
            if (state !== 3'd0 || count !== 3'(i + 1)) begin
                errors++; $display("FAIL jump_retire case%0d got state %0d count %0d exp 0 %0d", i, state, count, i + 1);
            end
        end
    endtask

    task automatic test_delayed_sto();
        do_reset();
        opcode = 4'h1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 2);
            sample();
            checks++;
            if (state !== 3'd1 || moore !== 5'b10100) begin
                errors++; $display("FAIL sto_fetch_wait i%0d got state %0d moore %b exp 1 10100", i, state, moore);
            end
            checks++;
            if (pulses !== ((i == 2) ? 7'b1100000 : 7'b0)) begin
                errors++; $display("FAIL sto_fetch_pulses i%0d got %b", i, pulses);
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        sample();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL sto_exec_addr got %0d exp 2", state); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 2);
            sample();
            checks++;
            if (state !== 3'd3 || moore !== 5'b10111) begin
                errors++; $display("FAIL sto_data_wait i%0d got state %0d moore %b exp 3 10111", i, state, moore);
            end
            checks++;
            if (pulses !== 7'b0) begin errors++; $display("FAIL sto_no_acc_load i%0d got %b exp 0000000", i, pulses); end
            next_cycle();
        end
        mem_ack = 1'b0;
        sample();
        checks++;
        if (state !== 3'd0 || count !== 3'd1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL sto_retire got state %0d count %0d we %b exp 0 1 0", state, count, mem_we);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        next_cycle();
        for (int i = 1; i <= 15; i++) begin
            sample();
            checks++;
            if (state !== 3'd1) begin errors++; $display("FAIL timeout_wait cyc%0d got %0d exp 1", i, state); end
            next_cycle();
        end
        sample();
        checks++;
        if (state !== 3'd6 || moore !== 5'b01000) begin
            errors++; $display("FAIL timeout_fault got state %0d moore %b exp 6 01000", state, moore);
        end
        next_cycle();
        mem_ack = 1'b1; step = 1'b1;
        repeat (3) next_cycle();
        sample();
        checks++;
        if (state !== 3'd6 || pulses !== 7'b0 || count !== 3'd0) begin
            errors++; $display("FAIL fault_terminal got state %0d pulses %b count %0d exp 6 0 0", state, pulses, count);
        end
        next_cycle();
        do_reset();
        sample();
        checks++;
        if (state !== 3'd0 || moore !== 5'b10100) begin
            errors++; $display("FAIL fault_recover got state %0d moore %b exp 0 10100", state, moore);
        end
    endtask

    task automatic test_last_ack_and_illegal();
        do_reset();
        next_cycle();
        for (int i = 1; i <= 15; i++) begin
            mem_ack = (i == 15);
            if (i == 15) begin
                sample();
                checks++;
                if (state !== 3'd1 || pulses !== 7'b1100000) begin
                    errors++; $display("FAIL last_ack got state %0d pulses %b exp 1 1100000", state, pulses);
                end
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        opcode = 4'h9;
        sample();
        checks++;
        if (state !== 3'd2 || fault !== 1'b0 || pulses !== 7'b0) begin
            errors++; $display("FAIL illegal_decode got state %0d fault %b pulses %b exp 2 0 0", state, fault, pulses);
        end
        next_cycle();
        sample();
        checks++;
        if (state !== 3'd6 || count !== 3'd0 || fault !== 1'b1) begin
            errors++; $display("FAIL illegal_fault got state %0d count %0d fault %b exp 6 0 1", state, count, fault);
        end
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1; mem_ack = 1'b1; opcode = 4'h8;
        repeat (2) next_cycle();
        sample();
        checks++;
        if (state !== 3'd2 || pulses !== 7'b0000001) begin
            errors++; $display("FAIL step_out_valid got state %0d pulses %b exp 2 0000001", state, pulses);
        end
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++;
            if (state !== 3'd5 || moore !== 5'b10000 || count !== 3'd1) begin
                errors++; $display("FAIL step_park i%0d got state %0d moore %b count %0d exp 5 10000 1", i, state, moore, count);
            end
            next_cycle();
        end
        step = 1'b1;
        next_cycle();
        sample();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL step_release got %0d exp 0", state); end
        next_cycle();
        next_cycle();
        next_cycle();
        sample();
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL step_held_parks got %0d exp 5", state); end
        next_cycle();
        sample();
        checks++;
        if (state !== 3'd0 || count !== 3'd2) begin
            errors++; $display("FAIL step_held_release got state %0d count %0d exp 0 2", state, count);
        end
        step = 1'b0;
        repeat (3) next_cycle();
        sample();
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL step_park2 got %0d exp 5", state); end
        step_mode = 1'b0;
        next_cycle();
        sample();
        checks++;
        if (state !== 3'd0 || count !== 3'd3) begin
            errors++; $display("FAIL step_mode_clear got state %0d count %0d exp 0 3", state, count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        step_mode = 1'b1; mem_ack = 1'b1; opcode = 4'h7;
        repeat (2) next_cycle();
        sample();
        checks++;
        if (state !== 3'd2 || pulses !== 7'b0) begin
            errors++; $display("FAIL stp_decode got state %0d pulses %b exp 2 0", state, pulses);
        end
        next_cycle();
        sample();
        checks++;
        if (state !== 3'd4 || moore !== 5'b00000 || count !== 3'd1) begin
            errors++; $display("FAIL stp_halted got state %0d moore %b count %0d exp 4 00000 1", state, moore, count);
        end
        next_cycle();
        step = 1'b1; opcode = 4'h0;
        repeat (3) next_cycle();
        sample();
        checks++;
        if (state !== 3'd4 || count !== 3'd1 || pulses !== 7'b0) begin
            errors++; $display("FAIL halt_terminal got state %0d count %0d pulses %b exp 4 1 0", state, count, pulses);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_ack = 1'b1; opcode = 4'h0;
        repeat (6) next_cycle();
        mem_ack = 1'b0;
        next_cycle();
        sample();
        checks++;
        if (state !== 3'd3 || mem_req !== 1'b1 || count !== 3'd1) begin
            errors++; $display("FAIL pre_reset got state %0d req %b count %0d exp 3 1 1", state, mem_req, count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || moore !== 5'b10000 || count !== 3'd0) begin
            errors++; $display("FAIL async_reset got state %0d moore %b count %0d exp 0 10000 0", state, moore, count);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_ack = 1'b1; opcode = 4'h8;
        repeat (27) next_cycle();
        sample();
        checks++;
        if (state !== 3'd0 || count !== 3'd7) begin
            errors++; $display("FAIL count_saturate got state %0d count %0d exp 0 7", state, count);
        end
    endtask

    initial begin
        test_reset();
        test_mem_ops();
        test_jumps();
        test_delayed_sto();
        test_timeout();
        test_last_ack_and_illegal();
        test_step();
        test_halt();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
